arb_mux: RTL
============

# arb_mux

Parametrised N-channel, W-bit registered arbitrating multiplexer with valid/ready handshakes. It generalises the fixed 2:1 and 3:1 selectors of the 16-bit datapath. Selection is by fixed priority or round-robin instead of a static select line, and the chosen word is held in a one-entry output register. It sits where several producers share one consumer: writeback sources, memory-request sources, or debug taps in the pipelined CPU.

## Interface
- WIDTH, 16, data width in bits (≥1)
- NUM_IN, 4, number of input channels (2..8, need not be a power of two)
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- SRC_W, derived = max(1, clog2(NUM_IN)), width of the source index
- clk  input  1  clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  NUM_IN*WIDTH  packed inputs; channel i occupies [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  channel i offers a word
- in_ready  output  NUM_IN  channel i word is accepted this cycle
- out_data  output  WIDTH  registered selected word
- out_src  output  SRC_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_src hold a word
- out_ready  input  1  consumer accepts the held word this cycle

## Operation
- Transfer on input i: in_valid[i] & in_ready[i]. Transfer on output: out_valid & out_ready.
- load = !out_valid | out_ready. The register can take a new word when it is empty or being drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - ARB_MODE=0: the lowest-index asserted in_valid.
  - ARB_MODE=1: the first asserted in_valid found searching upward from rr_ptr, wrapping NUM_IN-1 → 0.
- in_ready[i] = grant[i] & load. At most one in_ready is high per cycle. in_ready may depend combinationally on out_ready and in_valid. in_ready[i] never depends on in_data.
- On an input transfer from channel g: out_data ← word g, out_src ← g, out_valid ← 1.
  - In round-robin mode, rr_ptr ← (g == NUM_IN-1) ? 0 : g+1.
- Output transfer with no input transfer: out_valid ← 0. out_data and out_src keep their old values.
- Output transfer with an input transfer in the same cycle: the new word replaces the old one and out_valid stays 1. This gives full throughput.
- No transfer: all registers hold. rr_ptr updates only on an input transfer, never on valid alone.
- Sources must hold in_valid and in_data stable until accepted. The block guarantees out_data and out_src are stable while out_valid & !out_ready.
- rr_ptr ranges 0..NUM_IN-1. Unused encodings (non-power-of-two NUM_IN) are never reached.

## Timing
- Reset (reset_n low, asynchronous) forces out_valid=0, out_data=0, out_src=0, rr_ptr=0. It takes effect immediately regardless of clk.
- After reset, in_ready = grant, because the output register is empty.
- Reset mid-operation discards any held word. Pending inputs are re-arbitrated from rr_ptr=0 after release.
- Latency is 1 cycle: a word accepted at edge k is visible on out_data with out_valid=1 after edge k.
- Throughput is one word per cycle while out_ready stays high.
- Backpressure (out_valid=1, out_ready=0): all in_ready=0 and the held word is unchanged.
- No in_valid asserted: no grant and no pointer change. out_valid falls after the next output transfer.
- Simultaneous requests from all channels with out_ready=1 (round-robin): grants go 0,1,…,NUM_IN-1,0,… on consecutive cycles.

## Test plan
- Reset: drive reset_n=0 mid-stream with out_valid=1 → out_valid, out_data and out_src read 0 immediately with no clock edge; rr_ptr restarts at 0.
- Single channel, WIDTH=16, NUM_IN=4: ch2 presents 0xBEEF with out_ready=1 → in_ready=4'b0100 in that cycle; the next cycle shows out_data=0xBEEF, out_src=2, out_valid=1.
- Round-robin fairness: all four channels valid with data 0x1000+i and out_ready=1 → out_src sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Fixed priority, ARB_MODE=0: ch1 and ch3 continuously valid → only ch1 is ever granted; ch3 is granted only after ch1 drops in_valid.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 → all in_ready=0 and out_data/out_src unchanged. Release out_ready → the next grant is taken in that same cycle.
- Non-power-of-two wrap, NUM_IN=3, round-robin: grant ch2, then ch0 and ch2 both valid → ch0 is granted (pointer wrapped to 0), and out_src never exceeds 2.

Source files
------------

// File: rtl/arb_mux.sv
// N-channel registered arbitrating multiplexer with valid/ready handshakes.
// Fixed-priority or round-robin grant feeds a one-entry output register.
module arb_mux #(
  parameter int WIDTH    = 16,
  parameter int NUM_IN   = 4,
  parameter int ARB_MODE = 1,
  localparam int SRC_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  chan_data [NUM_IN];
  logic [NUM_IN-1:0] grant;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_any;
  logic              load;
  logic              in_xfer;

  logic [WIDTH-1:0]  data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              valid_q, valid_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Search starts at rr_ptr in round-robin mode and at 0 in fixed-priority mode.
  always_comb begin : arbitrate
    int               start;
    int               cand;
    logic [SRC_W-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    start     = (ARB_MODE == 1) ? int'(rr_ptr_q) : 0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = start + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      cand_idx = SRC_W'(cand);
      if (!grant_any && in_valid[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  assign load     = !valid_q || out_ready;
  assign in_ready = load ? grant : '0;
  assign in_xfer  = grant_any && load;

  always_comb begin : next_state
    data_d   = data_q;
    src_d    = src_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (in_xfer) begin
      data_d  = chan_data[grant_idx];
      src_d   = grant_idx;
      valid_d = 1'b1;
      if (ARB_MODE == 1) begin
        rr_ptr_d = (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      src_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule
